// File: rtl/sp_ram_loadable.sv
// rtl/sp_ram_loadable.sv - byte-enabled single-port RAM with byte-stream program loader (option: SP_RAM_OUTREG_EN)
module sp_ram_loadable #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 1024,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    gnt_o,
    input  logic                    ld_start_i,
    input  logic [LEN_WIDTH-1:0]    ld_len_i,
    input  logic                    ld_valid_i,
    input  logic [7:0]              ld_byte_i,
    output logic                    ld_ready_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int BSEL  = $clog2(NB);
    localparam int WORDS = NUM_BYTES / NB;
    localparam int WIDX  = $clog2(WORDS);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [BSEL-1:0] LAST_LANE = BSEL'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       wcnt_q;
    logic [BSEL-1:0]        bcnt_q;
    logic [DATA_WIDTH-1:0]  ld_buf_q;
    logic [DATA_WIDTH-1:0]  ld_word;
    logic [CNT_W-1:0]       len_clamp;
    logic [WIDX-1:0]        core_idx;
    logic                   core_acc;
    logic                   core_wr;
    logic                   ld_acc;
    logic                   ld_wr;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   unused_addr;

    logic [DATA_WIDTH-1:0]  mem [WORDS];

    assign core_idx    = addr_i[BSEL +: WIDX];
    assign unused_addr = ^addr_i;
    assign core_acc    = (state_q == S_IDLE) && en_i;
    assign core_wr     = core_acc && we_i;
    assign ld_acc      = (state_q == S_LOAD) && ld_valid_i;
    assign ld_wr       = ld_acc && (bcnt_q == LAST_LANE);

    // Clamp the requested word count to the array size so the loader never wraps.
    always_comb begin
        len_clamp = CNT_W'(ld_len_i);
        if (32'(ld_len_i) > WORDS) begin
            len_clamp = CNT_W'(WORDS);
        end
    end

    // The last lane comes straight from the input so a full word is written without a bubble.
    always_comb begin
        ld_word                   = ld_buf_q;
        ld_word[DATA_WIDTH-1 -: 8] = ld_byte_i;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d    = state_q;
        gnt_o      = 1'b0;
        ld_ready_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_o = 1'b1;
                if (ld_start_i) begin
                    state_d = (len_clamp == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (ld_wr && ((wcnt_q + CNT_W'(1)) == len_q)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Loader counters and byte packing; a reset drops any partial word.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            len_q    <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            ld_buf_q <= '0;
        end else if ((state_q == S_IDLE) && ld_start_i) begin
            len_q  <= len_clamp;
            wcnt_q <= '0;
            bcnt_q <= '0;
        end else if (ld_acc) begin
            ld_buf_q[{bcnt_q, 3'b000} +: 8] <= ld_byte_i;
            if (ld_wr) begin
                bcnt_q <= '0;
                wcnt_q <= wcnt_q + CNT_W'(1);
            end else begin
                bcnt_q <= bcnt_q + BSEL'(1);
            end
        end
    end

    // Memory array writes; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            if (ld_wr) begin
                mem[wcnt_q[WIDX-1:0]] <= ld_word;
            end else if (core_wr) begin
                for (int k = 0; k < NB; k++) begin
                    if (be_i[k]) begin
                        mem[core_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read register: read-first, holds when no access is accepted.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (core_acc) begin
            rdata_q <= mem[core_idx];
        end
    end

`ifdef SP_RAM_OUTREG_EN
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rdata_out_q;

    // Second output stage, advanced only in the cycle after an accepted read.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_vld_q    <= 1'b0;
            rdata_out_q <= '0;
        end else begin
            rd_vld_q <= core_acc;
            if (rd_vld_q) begin
                rdata_out_q <= rdata_q;
            end
        end
    end

    assign rdata_o = rdata_out_q;
`else
    assign rdata_o = rdata_q;
`endif

endmodule

// File: tb/tb_sp_ram_loadable.sv
// tb/tb_sp_ram_loadable.sv - scoreboard bench for sp_ram_loadable
module tb_sp_ram_loadable;

`ifdef SP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        we_i;
    logic [9:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;
    logic        gnt_o;
    logic        ld_start_i;
    logic [15:0] ld_len_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_ready_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int byte_cnt = 0;
    logic [31:0]    exp_q[$];
    logic [LAT-1:0] acc_pipe = '0;

    sp_ram_loadable dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .rdata_o    (rdata_o),
        .gnt_o      (gnt_o),
        .ld_start_i (ld_start_i),
        .ld_len_i   (ld_len_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_ready_o (ld_ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Track accepted accesses and loader events at the clock edge.
    always @(posedge clk) begin
        acc_pipe <= LAT'({acc_pipe, (en_i && gnt_o && !rst_i)});
        if (done_o) done_cnt++;
        if (ld_valid_i && ld_ready_o) byte_cnt++;
    end

    // Monitor: compare read data against the scoreboard once it is due.
    always @(negedge clk) begin
        if (acc_pipe[LAT-1]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata_unexpected: got 0x%08h with empty queue", rdata_o);
            end else begin
                check("rdata", rdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic core_access(input logic we, input logic [9:0] a, input logic [31:0] wd,
                               input logic [3:0] be, input logic [31:0] exp_rd);
        en_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] len);
        ld_start_i = 1'b1; ld_len_i = len;
        @(negedge clk);
        ld_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid_i = 1'b1; ld_byte_i = b;
        @(negedge clk);
        ld_valid_i = 1'b0;
    endtask

    logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] part [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        rst_i = 1'b1; en_i = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        ld_start_i = 1'b0; ld_len_i = '0; ld_valid_i = 1'b0; ld_byte_i = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_rdata", rdata_o, 32'h0);
        end
        check("rst_gnt", gnt_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ld_ready_o, 0);
        check("rst_done", done_o, 0);
        en_i = 1'b0; rst_i = 1'b0;
        @(negedge clk);

        start_load(16'd2);
        check("ld_busy", busy_o, 1);
        check("ld_ready", ld_ready_o, 1);
        check("ld_gnt", gnt_o, 0);
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        check("ld_done", done_o, 1);
        check("ld_ready_fin", ld_ready_o, 0);
        @(negedge clk);
        check("ld_done_clr", done_o, 0);
        check("ld_gnt_back", gnt_o, 1);

        core_access(1'b0, 10'h000, 32'h0, 4'h0, 32'h00000013);
        core_access(1'b0, 10'h004, 32'h0, 4'h0, 32'h00100093);
        core_access(1'b1, 10'h004, 32'hAABBCCDD, 4'b0101, 32'h00100093);
        core_access(1'b0, 10'h004, 32'h0, 4'h0, 32'h00BB00DD);
        core_access(1'b1, 10'h000, 32'hCAFEF00D, 4'b1111, 32'h00000013);
        core_access(1'b0, 10'h000, 32'h0, 4'h0, 32'hCAFEF00D);

        start_load(16'd0);
        check("len0_done", done_o, 1);
        check("len0_ready", ld_ready_o, 0);
        @(negedge clk);
        check("len0_gnt", gnt_o, 1);

        done_cnt = 0; byte_cnt = 0;
        start_load(16'hFFFF);
        for (int j = 0; j < 1024; j++) send_byte(8'(j));
        check("full_done", done_o, 1);
        ld_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        ld_valid_i = 1'b0;
        check("full_bytes", byte_cnt, 1024);
        check("full_done_cnt", done_cnt, 1);
        check("full_ready_off", ld_ready_o, 0);
        core_access(1'b0, 10'h000, 32'h0, 4'h0, 32'h03020100);
        core_access(1'b0, 10'h004, 32'h0, 4'h0, 32'h07060504);
        core_access(1'b0, 10'h3FC, 32'h0, 4'h0, 32'hFFFEFDFC);
        repeat (3) @(negedge clk);

        done_cnt = 0;
        start_load(16'd2);
        for (int i = 0; i < 4; i++) send_byte(part[i]);
        en_i = 1'b1; we_i = 1'b1; addr_i = 10'h004; wdata_i = 32'hFFFFFFFF; be_i = 4'hF;
        send_byte(part[4]);
        en_i = 1'b0; we_i = 1'b0;
        check("drop_hold", rdata_o, 32'hFFFEFDFC);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_gnt", gnt_o, 1);
        repeat (2) @(negedge clk);
        check("rst_mid_no_done", done_cnt, 0);
        core_access(1'b0, 10'h000, 32'h0, 4'h0, 32'h44332211);
        core_access(1'b0, 10'h004, 32'h0, 4'h0, 32'h07060504);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_loadable.md
# sp_ram_loadable

Parametrised single-port, byte-enabled instruction/data RAM with a built-in byte-stream program loader, replacing file-based initialisation in the core memory subsystem. A boot source (UART receiver, debug bridge) streams bytes that are packed little-endian into words and written sequentially from word 0. While a load is in progress the core port is blocked, and the core is held off via `busy_o`.

## Interface
- `ADDR_WIDTH`, 10: byte-address width of `addr_i`.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8, ≥ 16.
- `NUM_BYTES`, 1024: capacity in bytes; `WORDS = NUM_BYTES/(DATA_WIDTH/8)`.
- `LEN_WIDTH`, 16: width of the load-length field, in words.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: core access request.
- `we_i` in 1: core write (with `en_i`).
- `addr_i` in ADDR_WIDTH: core byte address; word index = `addr_i[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]`.
- `wdata_i` in DATA_WIDTH: core write data.
- `be_i` in DATA_WIDTH/8: byte enables; bit k covers `wdata_i[8k+7:8k]`.
- `rdata_o` out DATA_WIDTH: read data.
- `gnt_o` out 1: core port available (state IDLE).
- `ld_start_i` in 1: start-load pulse.
- `ld_len_i` in LEN_WIDTH: word count, sampled with `ld_start_i`.
- `ld_valid_i` in 1: `ld_byte_i` valid.
- `ld_byte_i` in 8: load byte.
- `ld_ready_o` out 1: loader accepts a byte this cycle.
- `busy_o` out 1: load in progress.
- `done_o` out 1: one-cycle pulse at load completion.

## Operation
- FSM: IDLE, LOAD, FINISH.
- IDLE: `gnt_o`=1. Core access when `en_i`. Write when `we_i`: only bytes with `be_i[k]`=1 update. Every enabled access reads the addressed word.
- IDLE→LOAD on `ld_start_i`:
  - Latch `len = min(ld_len_i, WORDS)`.
  - Clear the word counter `wcnt` and the byte counter `bcnt`.
  - If `len`=0, go directly to FINISH.
- LOAD: `ld_ready_o`=1, `busy_o`=1, `gnt_o`=0.
  - Each accepted byte (`ld_valid_i && ld_ready_o`) goes to lane `bcnt`. The first byte is bits [7:0].
  - On the last lane, the assembled word is written to `mem[wcnt]` with all byte enables in that same cycle. No extra cycle is needed, so the loader sustains 1 byte/cycle.
  - After the write, `wcnt++` and `bcnt` resets.
  - When `wcnt` reaches `len`, go to FINISH.
- FINISH: `done_o`=1 for one cycle, `busy_o`=1, then IDLE.
- Core requests while `gnt_o`=0 are dropped. No write occurs and `rdata_o` holds.
- `ld_start_i` outside IDLE is ignored. `ld_valid_i` outside LOAD is ignored.
- Loader address is bounded by the `len` clamp, so no wrap-around. Bytes beyond `len`×bytes-per-word are not accepted.
- Memory array is not reset. Contents survive `rst_i`.

## Timing
- Reset values: state IDLE, `rdata_o`=0, `gnt_o`=1, `ld_ready_o`=0, `busy_o`=0, `done_o`=0.
- Read latency: 1 cycle from `en_i` to `rdata_o`; 2 cycles with the output register (see Configuration).
- `rdata_o` holds its value when there is no accepted read.
- Read-during-write to the same word returns the old data (read-first).
- `ld_start_i` at edge N: `busy_o`=1 and `ld_ready_o`=1 from N+1.
- Last byte accepted at edge M: `done_o`=1 at M+1, `gnt_o`=1 at M+2.
- `rst_i` mid-load:
  - Returns to IDLE next cycle and the partial word is discarded.
  - Words already written remain.
  - No `done_o` is produced.

## Configuration
- `SP_RAM_OUTREG_EN` defined: adds a second register on `rdata_o`, giving read latency 2 cycles. The register resets to 0 and updates only one cycle after an accepted read.
- Not defined: single-register output, latency 1.

## Test plan
- Reset, then read word 0: `rdata_o`=0 throughout reset, `gnt_o`=1, `busy_o`=0.
- Load with `ld_len_i`=2 and bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 back-to-back:
  - `done_o` pulses one cycle after the 8th byte.
  - Core reads of addr 0x0 and 0x4 return 0x00000013 and 0x00100093.
- Core write addr 0x4, `wdata_i`=0xAABBCCDD, `be_i`=0b0101, then read: returns 0x00BB00DD over the loaded 0x00100093 → 0x00BB00DD becomes 0x00BB00DD|mask result 0x00BB00DD where bytes 1,3 remain 0x00,0x00.
- Core write plus read to the same address in one cycle: `rdata_o` shows old data; the next read shows new data.
- `ld_len_i`=0xFFFF with `WORDS`=256: exactly 1024 bytes are accepted, then `ld_ready_o`=0 and `done_o` pulses once.
- Assert `rst_i` after 5 bytes of a 2-word load:
  - Word 0 is retained, word 1 is unchanged.
  - `busy_o`=0 the next cycle, and no `done_o`.
- Repeat the read tests with `SP_RAM_OUTREG_EN` defined: data appears 2 cycles after `en_i`.
